// File: rtl/spmv_pe_pkg.sv
// Shared definitions for the SpMV processing-element shell: opcode values,
// command field positions, register indices and the controller state type.
package spmv_pe_pkg;

    localparam logic [7:0] OP_NOP             = 8'd0;
    localparam logic [7:0] OP_RST             = 8'd1;
    localparam logic [7:0] OP_LD              = 8'd2;
    localparam logic [7:0] OP_LD_DELTA_CODES  = 8'd3;
    localparam logic [7:0] OP_LD_PREFIX_CODES = 8'd4;
    localparam logic [7:0] OP_LD_COMMON_CODES = 8'd5;
    localparam logic [7:0] OP_STEADY          = 8'd6;

    localparam int OPCODE_ARG_PE = 8;
    localparam int OPCODE_ARG_1  = 16;
    localparam int OPCODE_ARG_2  = 24;

    localparam logic [7:0] PE_BROADCAST = 8'hFF;

    localparam int NUM_REGS         = 16;
    localparam int REG_WIDTH        = 64 - OPCODE_ARG_2;
    localparam int REG_STEADY_START = 0;
    localparam int REG_STEADY_END   = 1;
    localparam int REG_COPY_SRC     = 4;
    localparam int REG_COPY_DST     = 5;
    localparam int REG_COPY_BYTES   = 9;

    localparam int MEM_AW     = 48;
    localparam int SCRATCH_AW = 13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COPY   = 2'd1,
        ST_STEADY = 2'd2
    } pe_state_e;

    typedef struct packed {
        logic [REG_WIDTH-1:0] value;
        logic [7:0]           arg;
        logic [7:0]           pe;
        logic [7:0]           opcode;
    } pe_cmd_t;

    function automatic logic is_table_load(input logic [7:0] opcode);
        return (opcode == OP_LD_DELTA_CODES) || (opcode == OP_LD_PREFIX_CODES) ||
               (opcode == OP_LD_COMMON_CODES);
    endfunction

endpackage

// File: rtl/spmv_rsp_fifo.sv
// Memory-response buffer between the main-memory port and the scratchpad writer.
// First-word-fall-through: dout shows the head entry whenever empty is low.
module spmv_rsp_fifo
    import spmv_pe_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count_reg != CW'(DEPTH));
    assign do_pop  = pop && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign count = count_reg;

endmodule

// File: rtl/spmv_pe_core.sv
// SpMV PE shell: command-chain decoder, 16-entry register file, a table
// copier (main memory -> scratchpad) and the y-vector zero-store pass.
module spmv_pe_core
    import spmv_pe_pkg::*;
#(
    parameter logic [7:0] ID             = 8'd0,
    parameter int         RSP_FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [63:0]           op_in,
    output logic [63:0]           op_out,
    input  logic                  busy_in,
    output logic                  busy_out,
    output logic                  req_mem_ld,
    output logic                  req_mem_st,
    output logic [MEM_AW-1:0]     req_mem_addr,
    output logic [63:0]           req_mem_d_or_tag,
    input  logic                  req_mem_stall,
    input  logic                  rsp_mem_push,
    input  logic [2:0]            rsp_mem_tag,
    input  logic [63:0]           rsp_mem_q,
    output logic                  rsp_mem_stall,
    output logic                  req_scratch_ld,
    output logic                  req_scratch_st,
    output logic [SCRATCH_AW-1:0] req_scratch_addr,
    output logic [63:0]           req_scratch_d,
    input  logic                  req_scratch_stall,
    input  logic                  rsp_scratch_push,
    input  logic [63:0]           rsp_scratch_q,
    output logic                  rsp_scratch_stall
);

    localparam int              CW          = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int              LW          = REG_WIDTH - 3;
    localparam logic [CW:0]     CREDITS     = (CW + 1)'(RSP_FIFO_DEPTH);
    localparam logic [CW-1:0]   ALMOST_FULL = CW'(RSP_FIFO_DEPTH - 2);

    pe_cmd_t               cmd;
    logic                  addressed;
    logic                  cmd_rst;
    logic                  cmd_ld;
    logic                  start_copy;
    logic                  start_steady;

    pe_state_e             state_reg;
    pe_state_e             state_next;

    logic [REG_WIDTH-1:0]  regfile [NUM_REGS];

    logic [LW-1:0]         copy_len_reg;
    logic [LW-1:0]         issue_cnt_reg;
    logic [LW-1:0]         write_cnt_reg;
    logic [MEM_AW-1:0]     src_base_reg;
    logic [SCRATCH_AW-1:0] dst_base_reg;
    logic [MEM_AW-1:0]     steady_addr_reg;
    logic [MEM_AW-1:0]     steady_end_reg;
    logic [CW-1:0]         inflight_reg;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic [63:0]           fifo_dout;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  rsp_accept;
    logic [CW:0]           outstanding;

    logic                  ld_fire;
    logic                  st_fire;
    logic                  copy_last;
    logic                  steady_more;
    logic                  unused_ok;

    assign cmd       = op_in;
    assign addressed = (cmd.pe == ID) || (cmd.pe == PE_BROADCAST);
    assign cmd_rst   = addressed && (cmd.opcode == OP_RST);
    assign cmd_ld    = addressed && (cmd.opcode == OP_LD);

    // New work is refused until every load of an aborted copy has come back,
    // so stale responses can never land in a later copy's FIFO.
    assign start_copy   = addressed && is_table_load(cmd.opcode) &&
                          (state_reg == ST_IDLE) && (inflight_reg == '0);
    assign start_steady = addressed && (cmd.opcode == OP_STEADY) &&
                          (state_reg == ST_IDLE) && (inflight_reg == '0) &&
                          (regfile[REG_STEADY_START] < regfile[REG_STEADY_END]);

    assign outstanding = {1'b0, inflight_reg} + {1'b0, fifo_count};
    assign ld_fire     = (state_reg == ST_COPY) && !req_mem_stall &&
                         (issue_cnt_reg < copy_len_reg) && (outstanding < CREDITS);
    assign rsp_accept  = rsp_mem_push && (inflight_reg != '0);
    assign fifo_push   = rsp_accept && (state_reg == ST_COPY);
    assign fifo_pop    = (state_reg == ST_COPY) && !fifo_empty && !req_scratch_stall;
    assign copy_last   = fifo_pop && ((write_cnt_reg + LW'(1)) == copy_len_reg);

    assign steady_more = steady_addr_reg < steady_end_reg;
    assign st_fire     = (state_reg == ST_STEADY) && !req_mem_stall && steady_more;

    spmv_rsp_fifo #(
        .DEPTH (RSP_FIFO_DEPTH),
        .WIDTH (64)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cmd_rst),
        .push  (fifo_push),
        .din   (rsp_mem_q),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (cmd_rst) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_copy) begin
                        state_next = ST_COPY;
                    end else if (start_steady) begin
                        state_next = ST_STEADY;
                    end
                end
                ST_COPY: begin
                    if ((copy_len_reg == '0) || copy_last) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_STEADY: begin
                    if (!steady_more ||
                        (st_fire && ((steady_addr_reg + MEM_AW'(8)) >= steady_end_reg))) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_out <= '0;
        end else begin
            op_out <= op_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regfile[i] <= '0;
        end else if (cmd_rst) begin
            for (int i = 0; i < NUM_REGS; i++) regfile[i] <= '0;
        end else if (cmd_ld) begin
            regfile[cmd.arg[3:0]] <= cmd.value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copy_len_reg    <= '0;
            issue_cnt_reg   <= '0;
            write_cnt_reg   <= '0;
            src_base_reg    <= '0;
            dst_base_reg    <= '0;
            steady_addr_reg <= '0;
            steady_end_reg  <= '0;
        end else if (cmd_rst) begin
            copy_len_reg    <= '0;
            issue_cnt_reg   <= '0;
            write_cnt_reg   <= '0;
            src_base_reg    <= '0;
            dst_base_reg    <= '0;
            steady_addr_reg <= '0;
            steady_end_reg  <= '0;
        end else begin
            if (start_copy) begin
                copy_len_reg  <= regfile[REG_COPY_BYTES][REG_WIDTH-1:3];
                issue_cnt_reg <= '0;
                write_cnt_reg <= '0;
                src_base_reg  <= MEM_AW'(regfile[REG_COPY_SRC]);
                dst_base_reg  <= regfile[REG_COPY_DST][SCRATCH_AW+2:3];
            end else begin
                if (ld_fire)  issue_cnt_reg <= issue_cnt_reg + LW'(1);
                if (fifo_pop) write_cnt_reg <= write_cnt_reg + LW'(1);
            end
            if (start_steady) begin
                steady_addr_reg <= MEM_AW'(regfile[REG_STEADY_START]);
                steady_end_reg  <= MEM_AW'(regfile[REG_STEADY_END]);
            end else if (st_fire) begin
                steady_addr_reg <= steady_addr_reg + MEM_AW'(8);
            end
        end
    end

    // Loads still owed by memory; deliberately survives RST so the drain completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_reg <= '0;
        end else begin
            inflight_reg <= inflight_reg + CW'(ld_fire) - CW'(rsp_accept);
        end
    end

    always_comb begin
        req_mem_ld       = ld_fire;
        req_mem_st       = st_fire;
        req_mem_addr     = '0;
        req_mem_d_or_tag = '0;
        if (ld_fire) begin
            req_mem_addr     = src_base_reg + MEM_AW'({issue_cnt_reg, 3'b000});
            req_mem_d_or_tag = {61'b0, issue_cnt_reg[2:0]};
        end else if (st_fire) begin
            req_mem_addr     = steady_addr_reg;
            req_mem_d_or_tag = 64'h0;
        end
    end

    assign req_scratch_ld    = 1'b0;
    assign req_scratch_st    = fifo_pop;
    assign req_scratch_addr  = fifo_pop ? (dst_base_reg + write_cnt_reg[SCRATCH_AW-1:0]) : '0;
    assign req_scratch_d     = fifo_pop ? fifo_dout : '0;
    assign rsp_scratch_stall = 1'b0;
    assign rsp_mem_stall     = fifo_count >= ALMOST_FULL;
    assign busy_out          = (state_reg != ST_IDLE) || busy_in;

    assign unused_ok = ^{rsp_scratch_push, rsp_scratch_q, rsp_mem_tag, cmd.arg[7:4]};

endmodule

// File: tb/tb_spmv_pe_core.sv
// Randomized bench for spmv_pe_core: a latency-modelled main memory plus
// queue-based logs of every request, compared against expectations from the rules.
module tb_spmv_pe_core;
    import spmv_pe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] op_in = '0;
    logic [63:0] op_out;
    logic        busy_in = 1'b0;
    logic        busy_out;
    logic        req_mem_ld, req_mem_st;
    logic [47:0] req_mem_addr;
    logic [63:0] req_mem_d_or_tag;
    logic        req_mem_stall = 1'b0;
    logic        rsp_mem_push = 1'b0;
    logic [2:0]  rsp_mem_tag = '0;
    logic [63:0] rsp_mem_q = '0;
    logic        rsp_mem_stall;
    logic        req_scratch_ld, req_scratch_st;
    logic [12:0] req_scratch_addr;
    logic [63:0] req_scratch_d;
    logic        req_scratch_stall = 1'b0;
    logic        rsp_scratch_stall;

    always #5 clk = ~clk;

    spmv_pe_core #(.ID(8'd0), .RSP_FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .op_in(op_in), .op_out(op_out),
        .busy_in(busy_in), .busy_out(busy_out),
        .req_mem_ld(req_mem_ld), .req_mem_st(req_mem_st), .req_mem_addr(req_mem_addr),
        .req_mem_d_or_tag(req_mem_d_or_tag), .req_mem_stall(req_mem_stall),
        .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag), .rsp_mem_q(rsp_mem_q),
        .rsp_mem_stall(rsp_mem_stall),
        .req_scratch_ld(req_scratch_ld), .req_scratch_st(req_scratch_st),
        .req_scratch_addr(req_scratch_addr), .req_scratch_d(req_scratch_d),
        .req_scratch_stall(req_scratch_stall),
        .rsp_scratch_push(1'b0), .rsp_scratch_q(64'h0), .rsp_scratch_stall(rsp_scratch_stall)
    );

    typedef struct { int due; logic [2:0] tag; logic [63:0] data; } rsp_t;
    typedef struct { logic [47:0] a; logic [63:0] d; } xact_t;

    rsp_t  pend[$];
    xact_t ld_log[$];
    xact_t st_log[$];
    xact_t wr_log[$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          latency = 10;
    int          scr_stall_pct = 0;
    int          mem_stall_pct = 0;
    int          stall_from = -1;
    int          stall_to = -1;
    int          loads_issued = 0;
    int          rsp_count = 0;
    int          max_out = 0;
    logic [31:0] mem_seed;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [47:0] a);
        return {(a[31:0] * 32'h9E3779B1) ^ mem_seed, a[35:4] ^ ~mem_seed};
    endfunction

    // Memory/scratch environment: drive inputs on the falling edge, then sample
    // the outputs the next rising edge will act on.
    always @(negedge clk) begin
        cyc++;
        req_mem_stall     = ((cyc >= stall_from) && (cyc < stall_to)) ||
                            ($urandom_range(99) < mem_stall_pct);
        req_scratch_stall = ($urandom_range(99) < scr_stall_pct);
        if ((pend.size() > 0) && (pend[0].due <= cyc)) begin
            rsp_mem_push = 1'b1;
            rsp_mem_tag  = pend[0].tag;
            rsp_mem_q    = pend[0].data;
            void'(pend.pop_front());
            rsp_count++;
        end else begin
            rsp_mem_push = 1'b0;
        end
        #1;
        if (rst_n) begin
            if (req_mem_stall) check("no_req_in_stall", {62'b0, req_mem_ld, req_mem_st}, 64'h0);
            if (req_mem_ld || req_mem_st) check("ld_st_exclusive", 64'(req_mem_ld & req_mem_st), 64'h0);
            if (req_mem_ld && !req_mem_stall) begin
                ld_log.push_back('{req_mem_addr, req_mem_d_or_tag});
                pend.push_back('{cyc + latency, req_mem_d_or_tag[2:0], mem_word(req_mem_addr)});
                loads_issued++;
            end
            if (req_mem_st && !req_mem_stall) st_log.push_back('{req_mem_addr, req_mem_d_or_tag});
            if (req_scratch_st && !req_scratch_stall)
                wr_log.push_back('{48'(req_scratch_addr), req_scratch_d});
            if (loads_issued - rsp_count > max_out) max_out = loads_issued - rsp_count;
        end
    end

    task automatic send_op(input logic [7:0] opc, input logic [7:0] pe, input logic [7:0] arg,
                           input logic [39:0] val);
        @(negedge clk);
        op_in = {val, arg, pe, opc};
        $display("op   cyc=%0d opcode=%0d pe=%h arg=%0d value=%h", cyc, opc, pe, arg, val);
        @(negedge clk);
        op_in = '0;
    endtask

    task automatic wait_idle(input string tag, input int limit, output int cycles);
        cycles = 0;
        while (busy_out && (cycles < limit)) begin
            @(negedge clk);
            #2;
            cycles++;
        end
        check({tag, "_in_time"}, 64'(cycles < limit), 64'h1);
    endtask

    task automatic run_copy(input logic [7:0] opc, input logic [39:0] src, input logic [39:0] dst,
                            input logic [39:0] nbytes, input int lat, input int spct,
                            input int mpct, input bit window, output int cycles);
        int n;
        logic [12:0] wa;
        send_op(OP_LD, 8'd0, 8'd4, src);
        send_op(OP_LD, 8'd0, 8'd5, dst);
        send_op(OP_LD, 8'd0, 8'd9, nbytes);
        latency = lat; scr_stall_pct = spct; mem_stall_pct = mpct; max_out = 0;
        ld_log.delete(); wr_log.delete();
        if (window) begin stall_from = cyc + 30; stall_to = cyc + 50; end
        send_op(opc, 8'd0, 8'd0, 40'h0);
        #2;
        check("copy_busy", 64'(busy_out), 64'h1);
        wait_idle("copy", 30000, cycles);
        n = int'(nbytes >> 3);
        check("copy_loads", ld_log.size(), n);
        check("copy_writes", wr_log.size(), n);
        check("max_outstanding_ok", 64'(max_out <= 16), 64'h1);
        for (int k = 0; k < n; k++) begin
            wa = 13'((dst >> 3) + 40'(k));
            if (k < ld_log.size()) begin
                check("ld_addr", ld_log[k].a, 48'(src) + 48'(8 * k));
                check("ld_tag", ld_log[k].d, 64'(k % 8));
            end
            if (k < wr_log.size()) begin
                check("wr_addr", wr_log[k].a, 48'(wa));
                check("wr_data", wr_log[k].d, mem_word(48'(src) + 48'(8 * k)));
            end
        end
        $display("copy src=%h dst=%h words=%0d lat=%0d cycles=%0d maxout=%0d",
                 src, dst, n, lat, cycles, max_out);
        stall_from = -1; stall_to = -1; mem_stall_pct = 0; scr_stall_pct = 0;
    endtask

    task automatic run_steady(input logic [39:0] s0, input logic [39:0] s1, input int mpct);
        int n;
        int cycles;
        send_op(OP_LD, 8'd0, 8'd0, s0);
        send_op(OP_LD, 8'd0, 8'd1, s1);
        mem_stall_pct = mpct;
        st_log.delete();
        send_op(OP_STEADY, 8'd0, 8'd0, 40'h0);
        #2;
        check("steady_busy", 64'(busy_out), 64'(s0 < s1));
        wait_idle("steady", 5000, cycles);
        n = (s0 < s1) ? int'((s1 - s0 + 40'd7) >> 3) : 0;
        check("steady_stores", st_log.size(), n);
        for (int k = 0; k < n && k < st_log.size(); k++) begin
            check("st_addr", st_log[k].a, 48'(s0) + 48'(8 * k));
            check("st_data", st_log[k].d, 64'h0);
        end
        $display("steady start=%h end=%h stores=%0d cycles=%0d", s0, s1, n, cycles);
        mem_stall_pct = 0;
    endtask

    initial begin
        int cycles;
        int snap_wr;
        int snap_ld;
        logic [39:0] src, dst, nb;
        mem_seed = $urandom;
        repeat (3) @(negedge clk);
        #2;
        check("rst_op_out", op_out, 64'h0);
        check("rst_busy", 64'(busy_out), 64'h0);
        check("rst_reqs", {60'b0, req_mem_ld, req_mem_st, req_scratch_st, rsp_mem_stall}, 64'h0);
        check("rst_addr", 64'(req_mem_addr), 64'h0);
        rst_n = 1'b1;

        send_op(OP_LD, 8'd0, 8'd3, 40'h1234);
        #1;
        check("op_out_fwd", op_out, {40'h1234, 8'd3, 8'd0, OP_LD});
        check("ld_reg3", 64'(dut.regfile[3]), 64'h1234);
        check("idle_busy", 64'(busy_out), 64'h0);

        send_op(OP_LD, 8'd3, 8'd3, 40'hBEEF);
        #1;
        check("other_pe_fwd", op_out, {40'hBEEF, 8'd3, 8'd3, OP_LD});
        check("other_pe_ignored", 64'(dut.regfile[3]), 64'h1234);
        send_op(OP_LD, 8'hFF, 8'd3, 40'hFF_0000_ABCD);
        check("bcast_ld", 64'(dut.regfile[3]), 64'hFF_0000_ABCD);

        busy_in = 1'b1;
        @(negedge clk); #2;
        check("busy_in_fwd", 64'(busy_out), 64'h1);
        busy_in = 1'b0;

        run_copy(OP_LD_DELTA_CODES, 40'h1000, 40'h0, 40'd4096, 100, 0, 0, 1'b0, cycles);
        run_copy(OP_LD_PREFIX_CODES, 40'h2_0000, 40'(8192 * 8 - 16), 40'd32,
                 $urandom_range(2, 30), 20, 10, 1'b0, cycles);
        run_copy(OP_LD_COMMON_CODES, 40'h40_0000, 40'h80, 40'(8 * $urandom_range(64, 128)),
                 $urandom_range(3, 10), 60, 0, 1'b1, cycles);
        run_copy(OP_LD_DELTA_CODES, 40'h3000, 40'h10, 40'd7, 5, 0, 0, 1'b0, cycles);
        check("n0_one_cycle", cycles, 1);
        for (int r = 0; r < 3; r++) begin
            src = 40'($urandom) & ~40'h7;
            dst = 40'($urandom_range(0, 65535));
            nb  = 40'(8 * $urandom_range(1, 100) + $urandom_range(0, 7));
            run_copy(OP_LD_PREFIX_CODES, src, dst, nb, $urandom_range(2, 40),
                     $urandom_range(0, 50), $urandom_range(0, 30), 1'b0, cycles);
        end

        run_steady(40'h8000, 40'h8020, 0);
        run_steady(40'h8000, 40'h8000, 0);
        run_steady(40'(8 * $urandom_range(0, 1000)), 40'(8 * $urandom_range(1001, 1040)), 25);

        send_op(OP_LD, 8'd0, 8'd4, 40'h5_0000);
        send_op(OP_LD, 8'd0, 8'd5, 40'h0);
        send_op(OP_LD, 8'd0, 8'd9, 40'd3200);
        latency = 20;
        wr_log.delete(); ld_log.delete();
        send_op(OP_LD_DELTA_CODES, 8'd0, 8'd0, 40'h0);
        repeat (60) @(negedge clk);
        send_op(OP_RST, 8'd0, 8'd0, 40'h0);
        #2;
        check("rst_cmd_idle", 64'(busy_out), 64'h0);
        check("rst_cmd_regs", 64'(dut.regfile[4]), 64'h0);
        snap_wr = wr_log.size();
        snap_ld = ld_log.size();
        repeat (150) @(negedge clk);
        check("no_wr_after_rst", wr_log.size(), snap_wr);
        check("no_ld_after_rst", ld_log.size(), snap_ld);
        run_copy(OP_LD_COMMON_CODES, 40'h6000, 40'h40, 40'd64, 4, 10, 10, 1'b0, cycles);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
